// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the five-stage pipeline.
//
// Owns the program counter, fetches from an instruction memory that may insert
// wait states, selects the next PC from EX / ID / sequential sources and drives
// the IF/ID pipeline register. Holds on decode load-use bubbles and squashes
// wrong-path fetches after redirects, including fetches still outstanding.
//
// Optional feature macro: IF_IRQ_EN (adds the irq port and interrupt markers).
//
// Ports
//   clk, reset_b        clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word address, held until imem_ready
//   imem_ready/rdata    response strobe and instruction word
//   bubble              decode-stage load-use stall
//   PCSrcJ/PCSrcJR      decode-stage J / JR redirect, targets jump/jr_address
//   exception           decode-stage illegal instruction (to EXC_VEC)
//   EX_BranchTaken      EX-stage taken branch, target EX_BranchAddr
//   irq                 external interrupt (IF_IRQ_EN only)
//   IF_ID               {PC_Plus4, Instruction}
//   IF_IRQ              IF_ID slot is an interrupt marker
//
// state  | meaning
// S_REQ  | request outstanding at pc; its word will be used
// S_KILL | request outstanding at pc; its word is dropped, then jump to redir_pc
// S_HELD | no request; a fetched word waits in the buffer for bubble to clear
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        bubble,
  input  logic        PCSrcJ,
  input  logic        PCSrcJR,
  input  logic [31:0] jump_address,
  input  logic [31:0] jr_address,
  input  logic        exception,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchAddr,
`ifdef IF_IRQ_EN
  input  logic        irq,
`endif
  output logic [63:0] IF_ID,
  output logic        IF_IRQ
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_KILL = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [63:0] if_id_q, if_id_d;
  logic        if_irq_q, if_irq_d;

  logic [31:0] pc_seq;
  logic        irq_take;
  logic        redirect;
  logic [31:0] target;

  // Bit 31 is the kernel bit; sequential fetch never carries into it.
  assign pc_seq = {pc_q[31], pc_q[30:0] + 31'd4};

`ifdef IF_IRQ_EN
  // Interrupts are only taken from user space and never while a kill is
  // already pending, so the return address is always a real fetch PC.
  assign irq_take = irq && !pc_q[31] && (state_q != S_KILL) && !EX_BranchTaken;
`else
  assign irq_take = 1'b0;
`endif

  always_comb begin
    redirect = 1'b0;
    target   = 32'h0;
    if (EX_BranchTaken) begin
      redirect = 1'b1;
      target   = EX_BranchAddr;
    end else if (irq_take) begin
      redirect = 1'b1;
      target   = IRQ_VEC;
    end else if (!bubble && exception) begin
      redirect = 1'b1;
      target   = EXC_VEC;
    end else if (!bubble && PCSrcJR) begin
      redirect = 1'b1;
      target   = jr_address;
    end else if (!bubble && PCSrcJ) begin
      redirect = 1'b1;
      target   = jump_address;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    buf_d      = buf_q;
    if_id_d    = if_id_q;
    if_irq_d   = if_irq_q;

    if (redirect) begin
      // Interrupt marker carries the interrupted PC as the return address.
      if_id_d  = irq_take ? {pc_q, 32'h0} : 64'h0;
      if_irq_d = irq_take;
      if ((state_q != S_HELD) && !imem_ready) begin
        // Request still in flight: park the target until the word arrives.
        redir_pc_d = target;
        state_d    = S_KILL;
      end else begin
        pc_d    = target;
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            if (bubble) begin
              buf_d   = imem_rdata;
              state_d = S_HELD;
            end else begin
              if_id_d  = {pc_seq, imem_rdata};
              if_irq_d = 1'b0;
              pc_d     = pc_seq;
            end
          end else if (!bubble) begin
            if_id_d  = 64'h0;
            if_irq_d = 1'b0;
          end
        end
        S_KILL: begin
          if (imem_ready) begin
            pc_d    = redir_pc_q;
            state_d = S_REQ;
          end
          if (!bubble) begin
            if_id_d  = 64'h0;
            if_irq_d = 1'b0;
          end
        end
        S_HELD: begin
          if (!bubble) begin
            if_id_d  = {pc_seq, buf_q};
            if_irq_d = 1'b0;
            pc_d     = pc_seq;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      buf_q      <= 32'h0;
      if_id_q    <= 64'h0;
      if_irq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      buf_q      <= buf_d;
      if_id_q    <= if_id_d;
      if_irq_q   <= if_irq_d;
    end
  end

  // An abandoned request during reset is simply dropped by the memory.
  assign imem_req  = reset_b && (state_q != S_HELD);
  assign imem_addr = pc_q;
  assign IF_ID     = if_id_q;
  assign IF_IRQ    = if_irq_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
`ifdef IF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        bubble;
  logic        PCSrcJ, PCSrcJR;
  logic [31:0] jump_address, jr_address;
  logic        exception;
  logic        EX_BranchTaken;
  logic [31:0] EX_BranchAddr;
  logic        irq;
  logic [63:0] IF_ID;
  logic        IF_IRQ;
  logic [31:0] data_xor;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory returns a word derived from the address it is asked for.
  assign imem_rdata = imem_addr ^ data_xor;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .bubble         (bubble),
    .PCSrcJ         (PCSrcJ),
    .PCSrcJR        (PCSrcJR),
    .jump_address   (jump_address),
    .jr_address     (jr_address),
    .exception      (exception),
    .EX_BranchTaken (EX_BranchTaken),
    .EX_BranchAddr  (EX_BranchAddr),
`ifdef IF_IRQ_EN
    .irq            (irq),
`endif
    .IF_ID          (IF_ID),
    .IF_IRQ         (IF_IRQ)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    bubble = 0; PCSrcJ = 0; PCSrcJR = 0; exception = 0;
    EX_BranchTaken = 0; irq = 0;
    jump_address = 0; jr_address = 0; EX_BranchAddr = 0;
  endtask

  // Reference model: pc, whether the in-flight fetch is to be discarded (and
  // where to go afterwards), and whether a fetched word is parked for decode.
  logic [31:0] m_pc, m_pend, m_hold_word;
  logic        m_discard, m_hold_valid, m_irq;
  logic [63:0] m_ifid;

  function automatic logic [31:0] seq(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = 0; m_hold_word = 0;
    m_discard = 0; m_hold_valid = 0; m_irq = 0; m_ifid = 0;
  endtask

  task automatic model_step();
    logic        redir, take_irq, outstanding;
    logic [31:0] tgt, word;
    redir = 0; take_irq = 0; tgt = 0;
    word = m_pc ^ data_xor;
    outstanding = !m_hold_valid;
    if (EX_BranchTaken) begin redir = 1; tgt = EX_BranchAddr; end
    else if (IRQ_EN && irq && !m_pc[31] && !m_discard) begin
      redir = 1; take_irq = 1; tgt = IRQ_VEC;
    end
    else if (!bubble && exception) begin redir = 1; tgt = EXC_VEC; end
    else if (!bubble && PCSrcJR)   begin redir = 1; tgt = jr_address; end
    else if (!bubble && PCSrcJ)    begin redir = 1; tgt = jump_address; end

    if (redir) begin
      m_ifid = take_irq ? {m_pc, 32'h0} : 64'h0;
      m_irq  = take_irq;
      m_hold_valid = 0;
      if (outstanding && !imem_ready) begin
        m_discard = 1; m_pend = tgt;
      end else begin
        m_discard = 0; m_pc = tgt;
      end
    end else if (m_hold_valid) begin
      if (!bubble) begin
        m_ifid = {seq(m_pc), m_hold_word}; m_irq = 0;
        m_pc = seq(m_pc); m_hold_valid = 0;
      end
    end else if (m_discard) begin
      if (imem_ready) begin m_pc = m_pend; m_discard = 0; end
      if (!bubble) begin m_ifid = 0; m_irq = 0; end
    end else if (imem_ready) begin
      if (bubble) begin m_hold_word = word; m_hold_valid = 1; end
      else begin m_ifid = {seq(m_pc), word}; m_irq = 0; m_pc = seq(m_pc); end
    end else if (!bubble) begin
      m_ifid = 0; m_irq = 0;
    end
  endtask

  task automatic chk_model();
    chk("req",    imem_req,  !m_hold_valid);
    chk("addr",   imem_addr, m_pc);
    chk("if_id",  IF_ID,     m_ifid);
    chk("if_irq", IF_IRQ,    m_irq);
  endtask

  initial begin
    reset_b = 0; imem_ready = 1; data_xor = 0;
    clear_in();

    // Directed: reset, zero-wait streaming with data = address.
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_ifid", IF_ID, 0);
    chk("rst_irq", IF_IRQ, 0);
    reset_b = 1;
    #1;
    chk("d_addr0", imem_addr, 32'h8000_0000);
    chk("d_req0", imem_req, 1);
    step();
    chk("d_ifid0", IF_ID, 64'h80000004_80000000);
    chk("d_addr1", imem_addr, 32'h8000_0004);
    step();
    chk("d_ifid1", IF_ID, 64'h80000008_80000004);
    chk("d_addr2", imem_addr, 32'h8000_0008);
    step(); step();
    chk("d_addr10", imem_addr, 32'h8000_0010);

    // Bubble with a word arriving: parked, IF_ID frozen.
    bubble = 1;
    step();
    chk("d_held_req", imem_req, 0);
    chk("d_held_ifid", IF_ID, 64'h80000010_8000000C);
    step();
    chk("d_held_ifid2", IF_ID, 64'h80000010_8000000C);
    bubble = 0;
    step();
    chk("d_unheld_ifid", IF_ID, 64'h80000014_80000010);
    chk("d_unheld_addr", imem_addr, 32'h8000_0014);
    chk("d_unheld_req", imem_req, 1);

    // Priority: EX branch beats J.
    PCSrcJ = 1; jump_address = 32'h8000_0200;
    EX_BranchTaken = 1; EX_BranchAddr = 32'h8000_0300;
    step();
    chk("d_prio_addr", imem_addr, 32'h8000_0300);
    chk("d_prio_ifid", IF_ID, 0);
    clear_in();
    // J under bubble is ignored.
    PCSrcJ = 1; jump_address = 32'h8000_0200; bubble = 1;
    step();
    chk("d_jbub_addr", imem_addr, 32'h8000_0300);
    chk("d_jbub_req", imem_req, 0);
    clear_in();
    step();
    chk("d_jbub_ifid", IF_ID, 64'h80000304_80000300);

    // Exception from user space, then bit-31 preservation on wrap.
    PCSrcJ = 1; jump_address = 32'h0000_0040;
    step();
    chk("d_j40", imem_addr, 32'h0000_0040);
    clear_in(); exception = 1;
    step();
    chk("d_exc_addr", imem_addr, EXC_VEC);
    chk("d_exc_ifid", IF_ID, 0);
    clear_in(); PCSrcJ = 1; jump_address = 32'h7FFF_FFFC;
    step();
    clear_in();
    step();
    chk("d_wrap_ifid", IF_ID, 64'h00000000_7FFFFFFC);
    chk("d_wrap_addr", imem_addr, 32'h0000_0000);

    // Wait states with a branch in the first wait cycle.
    imem_ready = 0;
    step();
    chk("d_wait_ifid", IF_ID, 0);
    EX_BranchTaken = 1; EX_BranchAddr = 32'h8000_0100;
    step();
    clear_in();
    chk("d_kill_addr", imem_addr, 32'h0000_0000);
    chk("d_kill_req", imem_req, 1);
    step();
    chk("d_kill_addr2", imem_addr, 32'h0000_0000);
    imem_ready = 1;
    step();
    chk("d_kill_done", imem_addr, 32'h8000_0100);
    chk("d_kill_ifid", IF_ID, 0);

`ifdef IF_IRQ_EN
    PCSrcJ = 1; jump_address = 32'h0000_0050;
    step();
    clear_in(); irq = 1;
    step();
    chk("d_irq_ifid", IF_ID, 64'h00000050_00000000);
    chk("d_irq_flag", IF_IRQ, 1);
    chk("d_irq_addr", imem_addr, IRQ_VEC);
    step();
    chk("d_irq_ign_flag", IF_IRQ, 0);
    chk("d_irq_ign_addr", imem_addr, 32'h8000_0008);
    irq = 0;
`endif

    // Randomized phase against the reference model.
    reset_b = 0; data_xor = 32'h1357_9BDF;
    clear_in();
    model_reset();
    @(negedge clk);
    reset_b = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset_b = 0;
        #1;
        chk("r_mid_rst_req", imem_req, 0);
        chk("r_mid_rst_ifid", IF_ID, 0);
        model_reset();
        @(negedge clk);
        reset_b = 1;
      end
      #1;
      chk_model();
      imem_ready     = ($urandom_range(0, 2) != 0);
      bubble         = ($urandom_range(0, 3) == 0);
      EX_BranchTaken = ($urandom_range(0, 11) == 0);
      exception      = ($urandom_range(0, 15) == 0);
      PCSrcJR        = ($urandom_range(0, 9) == 0);
      PCSrcJ         = ($urandom_range(0, 9) == 0);
      irq            = ($urandom_range(0, 7) == 0);
      EX_BranchAddr  = $urandom & 32'hFFFF_FFFC;
      jr_address     = $urandom & 32'hFFFF_FFFC;
      jump_address   = $urandom & 32'h7FFF_FFFC;
      model_step();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline. It owns the program counter and fetches from an instruction memory that may insert wait states. It picks the next PC from the EX, ID and sequential redirect sources and drives the IF/ID pipeline register consumed by the decode stage. It holds on decode-stage load-use bubbles and squashes wrong-path fetches after redirects, including fetches still outstanding in memory.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset (kernel bit set)
- IRQ_VEC, 32'h8000_0004, interrupt target
- EXC_VEC, 32'h8000_0008, illegal-instruction/exception target
- clk  in  1  clock
- reset_b  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held with imem_addr until imem_ready
- imem_addr  out  32  fetch address (word aligned)
- imem_ready  in  1  response valid this cycle; completes the request
- imem_rdata  in  32  instruction word, valid with imem_ready
- bubble  in  1  decode-stage stall (load-use)
- PCSrcJ, PCSrcJR  in  1 each  decode-stage J / JR redirect
- jump_address, jr_address  in  32 each  J / JR targets
- exception  in  1  decode-stage illegal instruction
- EX_BranchTaken  in  1  EX-stage taken branch
- EX_BranchAddr  in  32  branch target
- irq  in  1  external interrupt (only with IF_IRQ_EN)
- IF_ID  out  64  {PC_Plus4[63:32], Instruction[31:0]}
- IF_IRQ  out  1  the IF_ID slot is an interrupt marker

## Operation
- Redirect priority, highest first: EX_BranchTaken, irq, exception, PCSrcJR, PCSrcJ.
- ID-sourced redirects (exception, PCSrcJR, PCSrcJ) only count when bubble=0. EX_BranchTaken always counts.
- Any accepted redirect loads IF_ID with a NOP (64'h0) and sets IF_IRQ=0. The interrupt case is the exception to this (see Configuration).
- Sequential next PC: {pc[31], pc[30:0]+31'd4}. Bit 31 never changes except through a redirect.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc.
  - KILL: imem_req=1, imem_addr=pc; the outstanding word will be discarded.
  - HELD: imem_req=0; a fetched word sits in a 1-entry buffer.
- REQ, imem_ready=1:
  - Redirect: pc<=target; stay in REQ.
  - Else if bubble=1: buffer<=rdata, go to HELD, IF_ID held.
  - Else: IF_ID<={pc+4, rdata}, pc<=pc+4.
- REQ, imem_ready=0:
  - Redirect: redir_pc<=target, go to KILL.
  - Else if bubble=1: IF_ID held.
  - Else: IF_ID<=NOP.
- KILL:
  - imem_ready=1: drop rdata, pc<=redir_pc, go to REQ.
  - A further redirect while in KILL overwrites redir_pc (newest wins). If it arrives in the same cycle as imem_ready, its target is used.
  - IF_ID<=NOP unless bubble=1.
- HELD:
  - Redirect: drop the buffer, pc<=target, go to REQ.
  - Else if bubble=0: IF_ID<={pc+4, buffer}, pc<=pc+4, go to REQ.
  - Else: IF_ID held.
- Reset: pc=RESET_PC, state=REQ, IF_ID=0, IF_IRQ=0. imem_req is forced to 0 while reset_b=0.
- Reset asserted mid-request: the outstanding response is ignored. The memory must tolerate the abandoned request.

## Timing
- Zero-wait memory gives one instruction per cycle. The instruction is in IF_ID at the clock edge where imem_ready=1.
- Redirect penalty with a zero-wait memory: the redirect cycle's IF_ID is NOP, and the target instruction reaches IF_ID one cycle later.
- A redirect during a wait state costs the remaining wait cycles plus one fetch.
- imem_addr and imem_req change only on clock edges. They are stable from the request cycle to the imem_ready cycle inclusive.
- bubble takes effect in the same cycle: IF_ID and pc do not update on that edge.

## Configuration
- IF_IRQ_EN defined:
  - irq port is present. An interrupt is taken when irq=1, pc[31]=0, state is REQ or HELD, and EX_BranchTaken=0.
  - On an interrupt: pc<=IRQ_VEC, IF_ID<={pc, 32'h0}, IF_IRQ<=1. The PC_Plus4 field carries the return address (the interrupted PC).
  - Any HELD buffer is dropped. An interrupt arriving while a request is outstanding in REQ routes through KILL.
- IF_IRQ_EN undefined: no irq port, IF_IRQ tied to 0, and the interrupt priority level is skipped.

## Test plan
- Reset release, zero-wait memory returning pc as data -> imem_addr 0x80000000, 0x80000004, 0x80000008; IF_ID = {0x80000004, 0x80000000}, then {0x80000008, 0x80000004}.
- bubble=1 for 2 cycles while imem_ready=1 at 0x80000010 -> state HELD, IF_ID unchanged; after bubble drops, IF_ID={0x80000014, word}, then the next fetch is 0x80000014.
- 3 wait cycles at 0x80000020, EX_BranchTaken with target 0x80000100 in wait cycle 1 -> imem_addr stays 0x80000020 until ready; the word is dropped; the next request is 0x80000100; IF_ID is NOP throughout.
- PCSrcJ=1 and EX_BranchTaken=1 in the same cycle (targets 0x80000200 / 0x80000300) -> the next fetch is 0x80000300. PCSrcJ=1 with bubble=1 -> ignored.
- exception=1 at pc 0x00000040 -> next fetch 0x80000008, IF_ID=NOP. The sequential fetch after 0x7FFFFFFC stays at 0x00000000 (bit 31 is kept).
- IF_IRQ_EN: irq=1 at pc 0x00000050 -> IF_ID={0x00000050, 0}, IF_IRQ=1, next fetch 0x80000004. irq=1 at pc 0x80000050 -> ignored.
